// File: rtl/divu_hilo_if.sv
// Issue/result bundle between the EX stage and the DIVU/HI/LO unit.
// Names match the EX-stage wiring so MFHI/MFLO muxing reads HiOut/LoOut directly.
interface divu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             busy;
    logic             done;

    modport master (
        output start, Signal, dataA, dataB,
        input  HiOut, LoOut, busy, done
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output HiOut, LoOut, busy, done
    );
endinterface

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned restoring divider that owns the HI/LO registers.
// One quotient bit per clock; HI = remainder, LO = quotient.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a DIVU issue; HI/LO hold the last result
// RUN    | one shift-subtract iteration per edge, WIDTH iterations
// FIN    | copy {R,Q} into HI/LO, pulse done, drop busy
module divu_hilo_unit #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  DIVU  = 6'b011011
) (
    input  logic       clk,
    input  logic       rst,
    divu_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] rq_q, rq_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     rem_ext;
    logic [WIDTH:0]     diff;
    logic               fits;

    // Shifted partial remainder kept WIDTH+1 bits wide so a remainder whose
    // MSB shifts out still compares correctly against the divisor.
    always_comb begin
        rem_ext = rq_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_ext - {1'b0, div_q};
        fits    = ~diff[WIDTH];
    end

    // Next-state logic for the sequencer, working register and HI/LO.
    always_comb begin
        state_d = state_q;
        rq_d    = rq_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.Signal == DIVU)) begin
                    rq_d    = {{WIDTH{1'b0}}, bus.dataA};
                    div_d   = bus.dataB;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rq_d  = {(fits ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0]),
                         rq_q[WIDTH-2:0], fits};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                hi_d    = rq_q[2*WIDTH-1:WIDTH];
                lo_d    = rq_q[WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any division without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rq_q    <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.HiOut = hi_q;
    assign bus.LoOut = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Scoreboard bench for divu_hilo_unit: issues DIVU operations, pushes the
// arithmetic result expected for each, and a monitor pops on every done.
module tb_divu_hilo_unit;
    localparam int         W       = 32;
    localparam logic [5:0] DIVU_FC = 6'b011011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divu_hilo_if #(.WIDTH(W)) bus ();

    divu_hilo_unit #(.WIDTH(W), .DIVU(DIVU_FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          e0;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc    = 0;
    int          n_done = 0;
    int          n_exp  = 0;
    logic [31:0] mhi    = '0;
    logic [31:0] mlo    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain unsigned division; divide by zero gives all ones / dividend.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding issue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", {31'b0, bus.done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("hi_result", bus.HiOut, e.hi);
                chk("lo_result", bus.LoOut, e.lo);
                chk("latency", cyc - e.e0, 32'd33);
            end
        end
    end

    // Issue one DIVU and follow it to completion. inject_at>0 pulses a second
    // DIVU with operands ia/ib just before edge E_inject_at; it must be ignored.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input int inject_at, input logic [31:0] ia, input logic [31:0] ib);
        logic [31:0] q, r;
        exp_t        e;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Signal = DIVU_FC;
        bus.dataA  = a;
        bus.dataB  = b;
        ref_div(a, b, q, r);
        e.hi = r;
        e.lo = q;
        e.e0 = cyc + 1;
        sb_q.push_back(e);
        n_exp++;
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.start = 1'b0;
                bus.dataA = $urandom;
                bus.dataB = $urandom;
            end
            chk("busy_in_flight", {31'b0, bus.busy}, 32'd1);
            chk("hi_hold", bus.HiOut, mhi);
            chk("lo_hold", bus.LoOut, mlo);
            if (inject_at > 0 && k == inject_at - 1) begin
                bus.start  = 1'b1;
                bus.Signal = DIVU_FC;
                bus.dataA  = ia;
                bus.dataB  = ib;
            end
            if (inject_at > 0 && k == inject_at) bus.start = 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_fin", {31'b0, bus.busy}, 32'd0);
        mhi = r;
        mlo = q;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
        chk("busy_stays_low", {31'b0, bus.busy}, 32'd0);
        chk("hi_final", bus.HiOut, mhi);
        chk("lo_final", bus.LoOut, mlo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.Signal = '0;
        bus.dataA  = '0;
        bus.dataB  = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", bus.HiOut, 32'd0);
        chk("rst_lo", bus.LoOut, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 0, '0, '0);
        run_div(32'hFFFF_FFFF, 32'd1, 0, '0, '0);
        run_div(32'd5, 32'd9, 0, '0, '0);
        run_div(32'h0000_3039, 32'd0, 0, '0, '0);
        run_div(32'd100, 32'd7, 5, 32'd50, 32'd5);
        run_div($urandom, $urandom_range(1, 1000), 33, 32'd77, 32'd3);

        // Non-DIVU strobes (MFHI, MFLO) must not start anything.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Signal = 6'd16;
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
        @(negedge clk);
        bus.Signal = 6'd18;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nondivu_busy", {31'b0, bus.busy}, 32'd0);
            chk("nondivu_done", {31'b0, bus.done}, 32'd0);
            chk("nondivu_hi", bus.HiOut, mhi);
            chk("nondivu_lo", bus.LoOut, mlo);
        end

        // Reset between E10 and E11 of a 1000/3 division: no result expected.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Signal = DIVU_FC;
        bus.dataA  = 32'd1000;
        bus.dataB  = 32'd3;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_hi", bus.HiOut, 32'd0);
        chk("abort_lo", bus.LoOut, 32'd0);
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", n_done, n_exp);
        run_div(32'd9, 32'd2, 0, '0, '0);

        for (int i = 0; i < 15; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 15);
            else rb = $urandom >> $urandom_range(0, 31);
            run_div(ra, rb, 0, '0, '0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        chk("done_count", n_done, n_exp);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/divu_hilo_unit.md
Name: divu_hilo_unit

Overview:
- Multi-cycle unsigned divider that executes DIVU and owns the HI/LO registers.
- Its HiOut/LoOut outputs drive the HI/LO inputs of the writeback-select mux in the EX stage, which is how MFHI and MFLO read them.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Exposes busy/done so the hazard unit can stall MFHI/MFLO while a division is in flight.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
- DIVU, 6'b011011, function code that launches a division.

Ports:
- clk  input  1  single system clock; everything is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle issue strobe from EX; qualified by Signal.
- Signal  input  6  function code of the issuing instruction.
- dataA  input  WIDTH  dividend (rs).
- dataB  input  WIDTH  divisor (rt).
- HiOut  output  WIDTH  HI register (remainder); registered.
- LoOut  output  WIDTH  LO register (quotient); registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when HI/LO have just been written.

Behaviour:
- Reset (asynchronous, any time, including mid-division):
  - State goes to IDLE; working registers and counter cleared.
  - HiOut=0, LoOut=0, busy=0, done=0.
  - No done pulse for the aborted operation.
- Internal state:
  - FSM states IDLE, RUN, FIN.
  - 2*WIDTH-bit working register {R,Q}.
  - WIDTH-bit divisor latch D.
  - Iteration counter of clog2(WIDTH)+1 bits.
- Issue:
  - Accepted only when state==IDLE and start==1 and Signal==DIVU.
  - start with any other Signal value: no effect.
  - On the accepting edge E0: R<=0, Q<=dataA, D<=dataB, count<=0, busy<=1, state->RUN.
  - Operands are used only at E0; later changes to dataA/dataB are ignored.
- RUN (edges E1..E_WIDTH), each edge:
  - Form T = {R,Q} shifted left by 1.
  - If T[upper WIDTH bits] >= D (unsigned): upper <= upper - D and Q[0] <= 1.
  - Otherwise: {R,Q} <= T with Q[0]=0.
  - count increments.
  - After the WIDTH-th iteration, state->FIN.
- FIN (edge E_WIDTH+1):
  - HiOut<=R, LoOut<=Q, done<=1, busy<=0, state->IDLE.
  - done deasserts on the next edge.
- Latency: HI/LO are valid and done is high in the cycle following edge E_(WIDTH+1), i.e. 33 clocks after issue for WIDTH=32.
- HiOut/LoOut hold their previous values throughout RUN. The hazard unit stalls MFHI/MFLO on busy.
- start while busy (RUN or FIN): ignored. The operation in flight is not disturbed or restarted.
- An issue on the same edge as FIN is ignored; a new issue is accepted from the next edge (state is IDLE).
- Divide by zero (D==0): no special case. The restoring algorithm yields LoOut = all ones and HiOut = dividend, with normal latency.
- Dividend < divisor: LoOut=0, HiOut=dividend.
- All arithmetic is unsigned, WIDTH-bit. The compare/subtract uses WIDTH+1 bits so a shifted remainder with its MSB set is handled correctly.

Test Plan:
- Basic division:
  - Stimulus: reset, then start=1, Signal=27, dataA=100, dataB=7.
  - Required: busy=1 from E0 through E32; at E33 HiOut=2, LoOut=14, done=1 for exactly one cycle, busy=0.
- Extremes:
  - Stimulus: dataA=32'hFFFFFFFF, dataB=1.
  - Required: LoOut=FFFFFFFF, HiOut=0.
  - Stimulus: then dataA=5, dataB=9.
  - Required: LoOut=0, HiOut=5.
- Divide by zero:
  - Stimulus: dataA=32'h00003039, dataB=0.
  - Required: after 33 clocks LoOut=FFFFFFFF, HiOut=00003039, single done pulse.
- Issue while busy:
  - Stimulus: start DIVU 100/7; at E5 pulse start with DIVU 50/5, changing dataA/dataB.
  - Required: result still Hi=2, Lo=14 at E33, only one done pulse; HI/LO unchanged (old values) during E1..E32.
- Reset mid-operation:
  - Stimulus: start DIVU 1000/3; assert rst asynchronously between E10 and E11.
  - Required: HiOut=0, LoOut=0, busy=0 immediately; no done pulse afterwards; a fresh DIVU 9/2 then completes with Hi=1, Lo=4.
- Non-DIVU strobe:
  - Stimulus: start=1 with Signal=16 (MFHI) and then 18 (MFLO).
  - Required: busy stays 0, done stays 0, HiOut/LoOut unchanged.
